rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two requesters: core writeback (primary) and a debug/loader port (secondary).
- Fixed priority to core, with a starvation guard that forces one debug grant after STARVE_MAX consecutive losses.
- Accepted writes are registered once and driven to the register file write port, one cycle after acceptance.
- Sits between the core writeback mux, the debug loader and reg_file.

Parameters:
- WIDTH, 32, data width of a register write.
- DEPTH, 5, register address width (2**DEPTH registers).
- STARVE_MAX, 4, consecutive debug losses before debug is forced; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- core_valid  in  1  core write request.
- core_ready  out  1  core request accepted this cycle; combinational.
- core_addr  in  DEPTH  core destination register.
- core_data  in  WIDTH  core write data.
- dbg_valid  in  1  debug write request.
- dbg_ready  out  1  debug request accepted this cycle; combinational.
- dbg_addr  in  DEPTH  debug destination register.
- dbg_data  in  WIDTH  debug write data.
- rf_we  out  1  registered write enable to reg_file.
- rf_waddr  out  DEPTH  registered write address.
- rf_wdata  out  WIDTH  registered write data.
- conflict_cnt  out  16  saturating count of cycles with both requesters valid.

Behaviour:
- Handshake:
  - A transfer occurs when valid && ready on the same rising edge.
  - valid must stay high, with stable addr/data, until accepted.
  - ready may depend on the other requester's valid.
  - At most one ready is high per cycle.
- FSM states: CORE_PRIO (reset state) and DBG_FORCE.
- CORE_PRIO:
  - core_ready = core_valid.
  - dbg_ready = dbg_valid && !core_valid.
  - Both valid: starve_cnt increments; core wins.
  - When a loss brings starve_cnt to STARVE_MAX: go to DBG_FORCE.
- DBG_FORCE:
  - dbg_ready = dbg_valid; core_ready = 0 regardless of core_valid.
  - On debug accept: go to CORE_PRIO, starve_cnt = 0.
  - If dbg_valid is low (protocol violation): go to CORE_PRIO, starve_cnt = 0, and grant nothing that cycle.
- starve_cnt:
  - Width $clog2(STARVE_MAX+1).
  - Clears on any debug accept, and in any cycle with dbg_valid low.
  - Never exceeds STARVE_MAX.
- Output stage:
  - On accept, rf_we/rf_waddr/rf_wdata load from the winner at the next edge (latency 1 cycle).
  - With no accept, rf_we = 0 next cycle; addr/data hold their last values.
- x0 rule: an accepted write to address 0 completes its handshake, but rf_we stays 0 for that cycle.
- conflict_cnt increments in every cycle with core_valid && dbg_valid, and saturates at 16'hFFFF.
- Reset:
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, conflict_cnt = 0, starve_cnt = 0, state = CORE_PRIO.
  - core_ready and dbg_ready are 0 while rst is high.
  - Reset mid-operation drops any write registered but not yet presented: rf_we is 0 on the cycle after reset.
- Simultaneous events:
  - A reset asserted in the same cycle as an accept wins; no write is issued.
  - A debug accept at the same edge as a loss cannot occur, since only one ready is high per cycle.

Decomposition:
- Shared package rf_arb_pkg:
  - State enum arb_state_t {CORE_PRIO, DBG_FORCE}.
  - Packed struct wr_req_t {addr[DEPTH], data[WIDTH]}.
  - Constant CONFLICT_CNT_W = 16.
- One sub-module: rf_wr_stage.
  - Registered rf_we/rf_waddr/rf_wdata with the x0 suppression.
  - Reuses the register block pattern with sync active-high reset.
- Grant logic, FSM and counters stay in the top module.

Test Plan:
- Reset, then idle 5 cycles -> rf_we = 0, both readies 0, conflict_cnt = 0.
- Core only: core_valid with addr 5, data 32'hDEADBEEF -> core_ready = 1 same cycle; next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 32'hDEADBEEF.
- Both valid continuously, STARVE_MAX = 4, dbg addr 7 / data 32'h1234:
  - Cycles 1-4: core wins, conflict_cnt increments each cycle.
  - Cycle 5: DBG_FORCE, dbg_ready = 1, core_ready = 0.
  - Cycle 6: rf_waddr = 7, rf_wdata = 32'h1234.
  - Afterwards core resumes and starve_cnt = 0.
- Debug write to addr 0, data 32'hFFFFFFFF, core idle -> dbg_ready = 1; next cycle rf_we = 0.
- Core valid, rst asserted for 1 cycle in the cycle after core accept -> rf_we = 0 on the following cycle; all outputs return to reset values.
- Force conflict_cnt to 16'hFFFE, hold both valid 3 cycles -> conflict_cnt reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and constants for the register-file write arbiter
package rf_arb_pkg;

   localparam int RF_WIDTH       = 32;
   localparam int RF_DEPTH       = 5;
   localparam int CONFLICT_CNT_W = 16;

   typedef enum logic {
      CORE_PRIO = 1'b0,
      DBG_FORCE = 1'b1
   } arb_state_t;

   // Default-width write request as seen by reg_file consumers
   typedef struct packed {
      logic [RF_DEPTH-1:0] addr;
      logic [RF_WIDTH-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/rf_wr_stage.sv
// rtl/rf_wr_stage.sv - registered write port toward reg_file with x0 write suppression
module rf_wr_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             acc_valid,
   input  logic [DEPTH-1:0] acc_addr,
   input  logic [WIDTH-1:0] acc_data,
   output logic             rf_we,
   output logic [DEPTH-1:0] rf_waddr,
   output logic [WIDTH-1:0] rf_wdata
);

   // x0 is hardwired: the handshake completes but the enable stays low
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= acc_valid && (acc_addr != '0);
         if (acc_valid) begin
            rf_waddr <= acc_addr;
            rf_wdata <= acc_data;
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - core/debug arbiter for the single register-file write port
module rf_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 5,
   parameter int STARVE_MAX = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      core_valid,
   output logic                      core_ready,
   input  logic [DEPTH-1:0]          core_addr,
   input  logic [WIDTH-1:0]          core_data,
   input  logic                      dbg_valid,
   output logic                      dbg_ready,
   input  logic [DEPTH-1:0]          dbg_addr,
   input  logic [WIDTH-1:0]          dbg_data,
   output logic                      rf_we,
   output logic [DEPTH-1:0]          rf_waddr,
   output logic [WIDTH-1:0]          rf_wdata,
   output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

   localparam int            SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [SW-1:0] LAST_LOSS  = SW'(STARVE_MAX - 1);

   arb_state_t       state, state_nxt;
   logic [SW-1:0]    starve_cnt, starve_nxt;
   logic             acc_valid;
   logic [DEPTH-1:0] acc_addr;
   logic [WIDTH-1:0] acc_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CORE_PRIO;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      core_ready = 1'b0;
      dbg_ready  = 1'b0;
      if (!rst) begin
         case (state)
            CORE_PRIO: begin
               core_ready = core_valid;
               dbg_ready  = dbg_valid && !core_valid;
               if (!dbg_valid || dbg_ready) begin
                  starve_nxt = '0;
               end else if (core_valid) begin
                  // debug lost this cycle; the loss that reaches the limit forces a debug slot
                  if (starve_cnt != STARVE_LIM) starve_nxt = starve_cnt + 1'b1;
                  if (starve_cnt == LAST_LOSS) state_nxt = DBG_FORCE;
               end
            end
            DBG_FORCE: begin
               dbg_ready  = dbg_valid;
               state_nxt  = CORE_PRIO;
               starve_nxt = '0;
            end
            default: begin
               state_nxt  = CORE_PRIO;
               starve_nxt = '0;
            end
         endcase
      end
   end

   assign acc_valid = core_ready || dbg_ready;
   assign acc_addr  = core_ready ? core_addr : dbg_addr;
   assign acc_data  = core_ready ? core_data : dbg_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (core_valid && dbg_valid && (conflict_cnt != '1)) begin
         conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

   rf_wr_stage #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_wr_stage (
      .clk       (clk),
      .rst       (rst),
      .acc_valid (acc_valid),
      .acc_addr  (acc_addr),
      .acc_data  (acc_data),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata)
   );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

   localparam int WIDTH      = 32;
   localparam int DEPTH      = 5;
   localparam int STARVE_MAX = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             core_valid = 1'b0;
   logic             core_ready;
   logic [DEPTH-1:0] core_addr = '0;
   logic [WIDTH-1:0] core_data = '0;
   logic             dbg_valid = 1'b0;
   logic             dbg_ready;
   logic [DEPTH-1:0] dbg_addr = '0;
   logic [WIDTH-1:0] dbg_data = '0;
   logic             rf_we;
   logic [DEPTH-1:0] rf_waddr;
   logic [WIDTH-1:0] rf_wdata;
   logic [15:0]      conflict_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Spec-level model: loss count, forced flag, last accepted write, conflict count
   int          m_losses = 0;
   bit          m_forced = 0;
   bit          m_we     = 0;
   int unsigned m_addr   = 0;
   int unsigned m_data   = 0;
   int          m_conf   = 0;
   bit          m_acc_c  = 0;
   bit          m_acc_d  = 0;

   always #5 clk = ~clk;

   rf_write_arbiter #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .core_valid   (core_valid),
      .core_ready   (core_ready),
      .core_addr    (core_addr),
      .core_data    (core_data),
      .dbg_valid    (dbg_valid),
      .dbg_ready    (dbg_ready),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .conflict_cnt (conflict_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: check this cycle's outputs, then advance the model across the next edge
   always @(negedge clk) begin
      bit ec, ed;
      ec = 0;
      ed = 0;
      if (!rst) begin
         if (m_forced) begin
            ed = dbg_valid;
         end else begin
            ec = core_valid;
            ed = dbg_valid && !core_valid;
         end
      end
      chk("core_ready", {31'd0, core_ready}, {31'd0, ec});
      chk("dbg_ready", {31'd0, dbg_ready}, {31'd0, ed});
      chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
      chk("rf_waddr", {27'd0, rf_waddr}, m_addr);
      chk("rf_wdata", rf_wdata, m_data);
      chk("conflict_cnt", {16'd0, conflict_cnt}, m_conf);
      m_acc_c = ec;
      m_acc_d = ed;
      if (rst) begin
         m_losses = 0;
         m_forced = 0;
         m_we     = 0;
         m_addr   = 0;
         m_data   = 0;
         m_conf   = 0;
      end else begin
         if (ec) begin
            m_we = (core_addr != 0);  m_addr = core_addr; m_data = core_data;
         end else if (ed) begin
            m_we = (dbg_addr != 0);   m_addr = dbg_addr;  m_data = dbg_data;
         end else begin
            m_we = 0;
         end
         if (core_valid && dbg_valid && m_conf < 65535) m_conf++;
         if (m_forced) begin
            m_forced = 0;
            m_losses = 0;
         end else if (!dbg_valid || ed) begin
            m_losses = 0;
         end else if (core_valid) begin
            m_losses++;
            if (m_losses == STARVE_MAX) m_forced = 1;
         end
      end
   end

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;

      // idle after reset
      cyc(5);
      chk("lit_idle_we", {31'd0, rf_we}, 32'd0);
      chk("lit_idle_core_ready", {31'd0, core_ready}, 32'd0);
      chk("lit_idle_dbg_ready", {31'd0, dbg_ready}, 32'd0);
      chk("lit_idle_conflict", {16'd0, conflict_cnt}, 32'd0);

      // core only
      core_valid = 1'b1; core_addr = 5'd5; core_data = 32'hDEADBEEF;
      #1;
      chk("lit_core_ready", {31'd0, core_ready}, 32'd1);
      cyc();
      core_valid = 1'b0;
      chk("lit_core_we", {31'd0, rf_we}, 32'd1);
      chk("lit_core_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("lit_core_wdata", rf_wdata, 32'hDEADBEEF);
      cyc();

      // starvation guard: core wins 4 times, then debug is forced
      core_valid = 1'b1; core_addr = 5'd3; core_data = 32'h0000_0033;
      dbg_valid  = 1'b1; dbg_addr  = 5'd7; dbg_data  = 32'h0000_1234;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("lit_starve_core_win", {31'd0, core_ready}, 32'd1);
         cyc();
      end
      chk("lit_conflict_4", {16'd0, conflict_cnt}, 32'd4);
      chk("lit_force_dbg_ready", {31'd0, dbg_ready}, 32'd1);
      chk("lit_force_core_ready", {31'd0, core_ready}, 32'd0);
      cyc();
      dbg_valid = 1'b0;
      #1;
      chk("lit_force_waddr", {27'd0, rf_waddr}, 32'd7);
      chk("lit_force_wdata", rf_wdata, 32'h0000_1234);
      chk("lit_conflict_5", {16'd0, conflict_cnt}, 32'd5);
      chk("lit_core_resumes", {31'd0, core_ready}, 32'd1);
      cyc();
      core_valid = 1'b0;
      cyc();

      // debug write to x0 completes but does not write
      dbg_valid = 1'b1; dbg_addr = 5'd0; dbg_data = 32'hFFFFFFFF;
      #1;
      chk("lit_x0_dbg_ready", {31'd0, dbg_ready}, 32'd1);
      cyc();
      dbg_valid = 1'b0;
      chk("lit_x0_we", {31'd0, rf_we}, 32'd0);
      cyc();

      // debug drops valid while forced: nothing granted, core wins after
      core_valid = 1'b1; core_addr = 5'd3; core_data = 32'h0000_0044;
      dbg_valid  = 1'b1; dbg_addr  = 5'd8; dbg_data  = 32'h0000_0088;
      cyc(4);
      dbg_valid = 1'b0;
      #1;
      chk("lit_viol_core_ready", {31'd0, core_ready}, 32'd0);
      chk("lit_viol_dbg_ready", {31'd0, dbg_ready}, 32'd0);
      cyc();
      chk("lit_viol_no_write", {31'd0, rf_we}, 32'd0);
      chk("lit_viol_core_back", {31'd0, core_ready}, 32'd1);
      cyc();
      core_valid = 1'b0;
      cyc();

      // reset right after a core accept
      core_valid = 1'b1; core_addr = 5'd9; core_data = 32'h0000_00AA;
      cyc();
      core_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("lit_rst_core_ready", {31'd0, core_ready}, 32'd0);
      cyc();
      rst = 1'b0;
      chk("lit_rst_we", {31'd0, rf_we}, 32'd0);
      chk("lit_rst_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("lit_rst_wdata", rf_wdata, 32'd0);
      chk("lit_rst_conflict", {16'd0, conflict_cnt}, 32'd0);
      cyc();

      // random traffic, valids held until accepted
      for (int i = 0; i < 300; i++) begin
         if (core_valid && m_acc_c) core_valid = 1'b0;
         if (dbg_valid && m_acc_d) dbg_valid = 1'b0;
         if (!core_valid && ($urandom_range(2) != 0)) begin
            core_valid = 1'b1;
            core_addr  = DEPTH'($urandom);
            core_data  = $urandom;
         end
         if (!dbg_valid && ($urandom_range(2) != 0)) begin
            dbg_valid = 1'b1;
            dbg_addr  = DEPTH'($urandom);
            dbg_data  = $urandom;
         end
         cyc();
      end
      core_valid = 1'b0;
      dbg_valid  = 1'b0;

      // conflict counter saturation
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      core_valid = 1'b1; core_addr = 5'd1; core_data = 32'h0000_0001;
      dbg_valid  = 1'b1; dbg_addr  = 5'd2; dbg_data  = 32'h0000_0002;
      cyc(65534);
      chk("lit_conflict_fffe", {16'd0, conflict_cnt}, 32'h0000_FFFE);
      cyc(3);
      chk("lit_conflict_sat", {16'd0, conflict_cnt}, 32'h0000_FFFF);
      cyc(2);
      chk("lit_conflict_hold", {16'd0, conflict_cnt}, 32'h0000_FFFF);
      core_valid = 1'b0;
      dbg_valid  = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
